plic_lite: RTL and testbench
============================

Name: plic_lite

Overview:
- Parametrised external-interrupt controller that aggregates NUM_SRC device interrupt lines into the single machine external interrupt (MEIP) fed to the CSR/trap logic.
- Each source has a configurable trigger mode (edge or level), an enable, and a priority.
- Sources are arbitrated against a global threshold.
- Software takes ownership of a source through a claim/complete handshake.
- Replaces the fixed three-source, fixed-priority scheme with per-source gateways and programmable priority.

Parameters:
NUM_SRC, 8, number of external interrupt sources (1..31)
PRIO_W, 3, priority field width; priority 0 = never interrupts
ID_W, $clog2(NUM_SRC+1), width of source ID; ID 0 = "no interrupt", source i uses ID i+1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
src_irq  input  NUM_SRC  raw device interrupt lines, synchronous to clk
src_edge  input  NUM_SRC  per-source mode: 1 = rising-edge triggered, 0 = level triggered
src_enable  input  NUM_SRC  per-source enable
src_prio  input  NUM_SRC*PRIO_W  per-source priority, source i at bits [i*PRIO_W +: PRIO_W]
threshold  input  PRIO_W  only priorities strictly greater than this interrupt
claim  input  1  one-cycle pulse: software claims the source in claim_id
complete  input  1  one-cycle pulse: software finished servicing complete_id
complete_id  input  ID_W  ID being completed
ext_irq  output  1  registered interrupt request to CSR mip.MEIP
claim_id  output  ID_W  registered ID of best eligible source, 0 if none
pending  output  NUM_SRC  per-source pending bits (readable as mip-style status)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: pending=0, ext_irq=0, claim_id=0; all internal src_q, inflight and held bits = 0. Reset mid-operation discards all pending, in-flight and held state.
- Input stage: src_irq is registered once into src_q. The previous src_q value is kept for edge detection.
- Per-source gateway states:
  - IDLE: no pending request, not in flight.
  - PEND: pending=1.
  - INFLIGHT: claimed, awaiting complete.
- Gateway transitions:
  - IDLE->PEND: edge mode, on src_q rising (prev 0, now 1); level mode, whenever src_q=1.
  - PEND->INFLIGHT: claim=1 and claim_id equals this source's ID. pending clears on the same edge.
  - INFLIGHT->IDLE: complete=1 and complete_id equals this source's ID.
  - complete for a source not in INFLIGHT, ID 0, or ID > NUM_SRC is ignored.
- Edge capture while busy: in edge mode, a rising edge seen in PEND or INFLIGHT sets a one-deep held bit. Further edges are lost.
  - On INFLIGHT->IDLE with held=1, the gateway goes directly to PEND and held clears.
  - Level mode has no held bit; if the level is still high after completion, the source re-pends on the next cycle.
- Disable: src_enable=0 does not clear pending; it only masks the source from arbitration.
- Arbitration (combinational, then registered):
  - Eligible sources: pending & enable & prio > threshold.
  - Winner: highest prio; ties go to the lowest ID.
  - claim_id <= winner ID, or 0 if none; ext_irq <= (winner != 0).
- Latency: src_irq high sampled at edge N -> src_q at N -> pending at N+1 -> ext_irq/claim_id at N+2.
- Claim rules:
  - claim with claim_id=0 is a no-op.
  - After a claim, the claimed source is excluded the next cycle, so claim_id/ext_irq update at edge+1 to the next winner or 0.
- Simultaneous events:
  - claim of X and complete of Y in the same cycle are both applied.
  - claim and complete can never target the same ID, since a PEND source is not INFLIGHT.
  - Edge arriving in the same cycle as its complete goes to PEND, not held.
- Config changes: changes to prio, threshold or enable take effect on the next registered arbitration result, one cycle later.

Decomposition:
- Shared definitions file (def.v): CAUSE_EXTERNAL_INTERRUPT, the MEIP bit index, and the ID 0 = none constant.
- Sub-module plic_gateway, instantiated NUM_SRC times by generate. It holds src_q, prev, pending, inflight and held, with inputs mode, claim_hit and complete_hit.
- Top level holds the priority/ID arbiter and the output registers.

Test Plan:
- Reset then level source 2 (ID 3), prio 5, threshold 0, enabled; src_irq[2]=1 -> ext_irq=1, claim_id=3 two cycles later; claim -> pending[2]=0 and ext_irq=0 next cycle; complete ID 3 with line still high -> re-pends, ext_irq=1 again.
- Edge sources 1 and 4, both prio 3, rising in the same cycle -> claim_id=2 (lower ID wins tie); claim -> claim_id=5 next cycle.
- Edge source 0 claimed (INFLIGHT); pulse src_irq[0] twice -> no pending; complete ID 1 -> pending[0]=1 exactly once; second edge lost.
- Source 3 prio 2 with threshold 2 -> ext_irq stays 0; threshold set to 1 -> ext_irq=1, claim_id=4 one cycle later; src_enable[3]=0 -> ext_irq=0 while pending[3] stays 1.
- complete with ID 0, ID 9 (NUM_SRC=8), and the ID of a non-inflight source -> no state change. claim while claim_id=0 -> no change.
- Assert reset mid-operation (two pending sources, one inflight) -> pending=0, ext_irq=0, claim_id=0 immediately; after release, level lines still high re-pend within 2 cycles.

Source files
------------

// File: rtl/plic_lite_pkg.sv
// Shared definitions for the plic_lite interrupt controller.
// Holds the "no interrupt" ID and the per-source gateway state encoding.
package plic_lite_pkg;

  // Claim ID reported when no source is eligible.
  localparam int unsigned ID_NONE = 0;

  // Gateway states; bit 0 doubles as the pending flag.
  typedef enum logic [1:0] {
    GW_IDLE     = 2'b00,
    GW_PEND     = 2'b01,
    GW_INFLIGHT = 2'b10
  } gw_state_e;

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: input register, edge/level trigger,
// pending / in-flight tracking and a one-deep held edge.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   irq           - raw device line (synchronous to clk)
//   mode          - 1 = rising-edge triggered, 0 = level triggered
//   claim_hit     - software claims this source this cycle
//   complete_hit  - software completes this source this cycle
//   pending       - source is waiting for a claim
module plic_gateway
  import plic_lite_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic mode,
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pending
);

  logic      src_q;
  logic      prev;
  logic      held;
  logic      held_next;
  logic      rise;
  logic      trig;
  gw_state_e state;
  gw_state_e state_next;

  assign rise = src_q & ~prev;
  assign trig = mode ? rise : src_q;

  // State, input-stage and held registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q <= 1'b0;
      prev  <= 1'b0;
      held  <= 1'b0;
      state <= GW_IDLE;
    end else begin
      src_q <= irq;
      prev  <= src_q;
      held  <= held_next;
      state <= state_next;
    end
  end

  // Next-state logic for the gateway.
  always_comb begin
    state_next = state;
    held_next  = held;
    case (state)
      GW_IDLE: begin
        if (trig) state_next = GW_PEND;
      end
      GW_PEND: begin
        if (claim_hit) state_next = GW_INFLIGHT;
        if (mode && rise) held_next = 1'b1;
      end
      GW_INFLIGHT: begin
        if (complete_hit) begin
          // A held edge or an edge landing with the complete re-pends at once.
          held_next  = 1'b0;
          state_next = (held || (mode && rise)) ? GW_PEND : GW_IDLE;
        end else if (mode && rise) begin
          held_next = 1'b1;
        end
      end
      default: begin
        state_next = GW_IDLE;
        held_next  = 1'b0;
      end
    endcase
  end

  // Pending is a direct decode of the state register.
  assign pending = state[0];

endmodule

// File: rtl/plic_lite.sv
// Lightweight external-interrupt controller: per-source gateways, a
// priority/threshold arbiter and registered MEIP / claim ID outputs.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   src_irq/edge/enable   - per-source line, trigger mode, enable
//   src_prio              - per-source priority, source i at [i*PRIO_W +: PRIO_W]
//   threshold             - priorities strictly above this may interrupt
//   claim                 - claim the source currently shown in claim_id
//   complete, complete_id - finish servicing complete_id
//   ext_irq, claim_id     - registered arbitration result
//   pending               - per-source pending status
module plic_lite
  import plic_lite_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3,
  parameter int unsigned ID_W    = $clog2(NUM_SRC + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_irq,
  input  logic [NUM_SRC-1:0]        src_edge,
  input  logic [NUM_SRC-1:0]        src_enable,
  input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
  input  logic [PRIO_W-1:0]         threshold,
  input  logic                      claim,
  input  logic                      complete,
  input  logic [ID_W-1:0]           complete_id,
  output logic                      ext_irq,
  output logic [ID_W-1:0]           claim_id,
  output logic [NUM_SRC-1:0]        pending
);

  logic [NUM_SRC-1:0] claim_hit;
  logic [NUM_SRC-1:0] complete_hit;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;

  // One gateway per source; source i answers to ID i+1.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign claim_hit[gi]    = claim && (claim_id == ID_W'(gi + 1));
    assign complete_hit[gi] = complete && (complete_id == ID_W'(gi + 1));

    plic_gateway u_gw (
      .clk          (clk),
      .reset        (reset),
      .irq          (src_irq[gi]),
      .mode         (src_edge[gi]),
      .claim_hit    (claim_hit[gi]),
      .complete_hit (complete_hit[gi]),
      .pending      (pending[gi])
    );
  end

  // Eligibility; the source being claimed is masked so it never wins twice.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending[i] && !claim_hit[i] && src_enable[i] &&
                    (src_prio[i*PRIO_W +: PRIO_W] > threshold);
    end
  end

  // Highest priority wins; strict compare keeps the lowest ID on ties.
  always_comb begin
    best_id   = ID_W'(ID_NONE);
    best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (src_prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = src_prio[i*PRIO_W +: PRIO_W];
        best_id   = ID_W'(i + 1);
      end
    end
  end

  // Registered arbitration result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      claim_id <= ID_W'(ID_NONE);
      ext_irq  <= 1'b0;
    end else begin
      claim_id <= best_id;
      ext_irq  <= (best_id != ID_W'(ID_NONE));
    end
  end

endmodule

// File: tb/tb_plic_lite.sv
// Self-checking bench for plic_lite: directed scenarios followed by a
// randomized phase, all checked against a behavioural per-source model.
module tb_plic_lite;

  localparam int unsigned NS = 8;
  localparam int unsigned PW = 3;
  localparam int unsigned IW = 4;

  localparam int ST_IDLE = 0;
  localparam int ST_PEND = 1;
  localparam int ST_INF  = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NS-1:0]  src_irq = '0;
  logic [NS-1:0]  src_edge = '0;
  logic [NS-1:0]  src_enable = '0;
  logic [NS*PW-1:0] src_prio = '0;
  logic [PW-1:0]  threshold = '0;
  logic           claim = 1'b0;
  logic           complete = 1'b0;
  logic [IW-1:0]  complete_id = '0;
  logic           ext_irq;
  logic [IW-1:0]  claim_id;
  logic [NS-1:0]  pending;

  int vectors = 0;
  int miscompares = 0;

  // Model state: registered line, previous line, gateway state, held edge.
  int        m_sq [NS];
  int        m_pv [NS];
  int        m_st [NS];
  int        m_hd [NS];
  logic [IW-1:0] m_cid;
  logic      m_ext;

  plic_lite #(.NUM_SRC(NS), .PRIO_W(PW), .ID_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .src_irq     (src_irq),
    .src_edge    (src_edge),
    .src_enable  (src_enable),
    .src_prio    (src_prio),
    .threshold   (threshold),
    .claim       (claim),
    .complete    (complete),
    .complete_id (complete_id),
    .ext_irq     (ext_irq),
    .claim_id    (claim_id),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NS-1:0] m_pending();
    logic [NS-1:0] p;
    p = '0;
    for (int i = 0; i < NS; i++) p[i] = (m_st[i] == ST_PEND);
    return p;
  endfunction

  task automatic check_all();
    chk("pending", 32'(pending), 32'(m_pending()));
    chk("ext_irq", 32'(ext_irq), 32'(m_ext));
    chk("claim_id", 32'(claim_id), 32'(m_cid));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_sq[i] = 0; m_pv[i] = 0; m_st[i] = ST_IDLE; m_hd[i] = 0;
    end
    m_cid = '0;
    m_ext = 1'b0;
  endtask

  // Advance one clock; model computes the post-edge state from pre-edge values.
  task automatic tick();
    int nst [NS];
    int nhd [NS];
    int nsq [NS];
    int bp;
    int bid;
    bp = 0;
    bid = 0;
    for (int i = 0; i < NS; i++) begin
      bit rise, trig, clm, cmp;
      int p;
      rise = (m_sq[i] == 1) && (m_pv[i] == 0);
      trig = src_edge[i] ? rise : (m_sq[i] == 1);
      clm  = claim && (m_cid == 4'(i + 1));
      cmp  = complete && (complete_id == 4'(i + 1)) && (m_st[i] == ST_INF);
      nst[i] = m_st[i];
      nhd[i] = m_hd[i];
      nsq[i] = int'(src_irq[i]);
      if (m_st[i] == ST_IDLE) begin
        if (trig) nst[i] = ST_PEND;
      end else if (m_st[i] == ST_PEND) begin
        if (clm) nst[i] = ST_INF;
        if (src_edge[i] && rise) nhd[i] = 1;
      end else begin
        if (cmp) begin
          nst[i] = (m_hd[i] == 1 || (src_edge[i] && rise)) ? ST_PEND : ST_IDLE;
          nhd[i] = 0;
        end else if (src_edge[i] && rise) begin
          nhd[i] = 1;
        end
      end
      p = int'(src_prio[i*PW +: PW]);
      if (m_st[i] == ST_PEND && !clm && src_enable[i] && p > int'(threshold) && p > bp) begin
        bp = p;
        bid = i + 1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      m_pv[i] = m_sq[i];
      m_sq[i] = nsq[i];
      m_st[i] = nst[i];
      m_hd[i] = nhd[i];
    end
    m_cid = 4'(bid);
    m_ext = (bid != 0);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_claim();
    claim = 1'b1; tick(); claim = 1'b0;
  endtask

  task automatic pulse_complete(input int id);
    complete = 1'b1; complete_id = 4'(id); tick(); complete = 1'b0; complete_id = '0;
  endtask

  // Asynchronous reset, checked before any clock edge, held across one edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_ext_irq", 32'(ext_irq), 32'h0);
    chk("rst_claim_id", 32'(claim_id), 32'h0);
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    do_reset();
    src_enable = '1;
    threshold  = 3'd0;

    // Level source 2 (ID 3): request, claim, complete with line still high.
    src_prio[2*PW +: PW] = 3'd5;
    src_irq[2] = 1'b1;
    ticks(3);
    chk("lvl_claim_id", 32'(claim_id), 32'd3);
    chk("lvl_ext_irq", 32'(ext_irq), 32'd1);
    pulse_claim();
    chk("lvl_claimed_pend", 32'(pending[2]), 32'd0);
    chk("lvl_claimed_ext", 32'(ext_irq), 32'd0);
    pulse_complete(3);
    ticks(2);
    chk("lvl_repend_ext", 32'(ext_irq), 32'd1);
    src_irq[2] = 1'b0;
    pulse_claim();
    pulse_complete(3);
    ticks(2);
    src_prio = '0;

    // Edge sources 1 and 4 tie at priority 3; lower ID wins.
    src_edge[1] = 1'b1; src_edge[4] = 1'b1;
    src_prio[1*PW +: PW] = 3'd3; src_prio[4*PW +: PW] = 3'd3;
    src_irq[1] = 1'b1; src_irq[4] = 1'b1;
    ticks(3);
    chk("tie_claim_id", 32'(claim_id), 32'd2);
    pulse_claim();
    chk("tie_next_id", 32'(claim_id), 32'd5);
    pulse_claim();
    src_irq[1] = 1'b0; src_irq[4] = 1'b0;
    pulse_complete(2);
    pulse_complete(5);
    ticks(2);

    // Edge source 0: two edges while in flight, only one survives.
    src_edge[0] = 1'b1;
    src_prio[0 +: PW] = 3'd4;
    src_irq[0] = 1'b1;
    ticks(3);
    src_irq[0] = 1'b0;
    pulse_claim();
    src_irq[0] = 1'b1; tick();
    src_irq[0] = 1'b0; tick();
    src_irq[0] = 1'b1; tick();
    src_irq[0] = 1'b0; ticks(2);
    chk("held_no_pend", 32'(pending[0]), 32'd0);
    pulse_complete(1);
    chk("held_repend", 32'(pending[0]), 32'd1);
    tick();
    pulse_claim();
    pulse_complete(1);
    ticks(3);
    chk("held_lost_edge", 32'(pending[0]), 32'd0);

    // Threshold and enable masking on level source 3 (ID 4).
    src_prio = '0;
    src_prio[3*PW +: PW] = 3'd2;
    threshold = 3'd2;
    src_irq[3] = 1'b1;
    ticks(4);
    chk("thr_masked", 32'(ext_irq), 32'd0);
    threshold = 3'd1;
    tick();
    chk("thr_open_ext", 32'(ext_irq), 32'd1);
    chk("thr_open_id", 32'(claim_id), 32'd4);
    src_enable[3] = 1'b0;
    tick();
    chk("dis_ext", 32'(ext_irq), 32'd0);
    chk("dis_pend", 32'(pending[3]), 32'd1);

    // Ignored completes and a claim with nothing to claim.
    pulse_complete(0);
    pulse_complete(9);
    pulse_complete(5);
    pulse_claim();
    chk("noop_pend", 32'(pending[3]), 32'd1);

    // Reset mid-operation with pending and in-flight sources.
    src_enable = '1;
    src_prio[5*PW +: PW] = 3'd6;
    src_prio[6*PW +: PW] = 3'd1;
    src_edge[6] = 1'b1;
    src_irq[5] = 1'b1; src_irq[6] = 1'b1;
    ticks(3);
    pulse_claim();
    ticks(2);
    do_reset();
    ticks(2);
    chk("post_rst_pend", 32'(pending & 8'h28), 32'h28);

    // Randomized phase.
    for (int c = 0; c < 600; c++) begin
      if (c % 100 == 0) begin
        src_edge = 8'($urandom);
        threshold = 3'($urandom_range(0, 3));
        for (int i = 0; i < NS; i++) src_prio[i*PW +: PW] = 3'($urandom);
      end
      if ($urandom_range(0, 19) == 0) src_enable = 8'($urandom);
      src_irq = 8'($urandom) & 8'($urandom);
      claim = ($urandom_range(0, 3) == 0);
      complete = ($urandom_range(0, 2) == 0);
      complete_id = 4'($urandom_range(0, 10));
      for (int i = 0; i < NS; i++)
        if (m_st[i] == ST_INF && $urandom_range(0, 1) == 1) complete_id = 4'(i + 1);
      tick();
    end
    claim = 1'b0;
    complete = 1'b0;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
